larger_sweep_ctrl: RTL and testbench
====================================

LARGER_SWEEP_CTRL -- requirements
Module: larger_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, legal 1..15: cycles each input vector is held before the outputs are sampled.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a sweep; ignored unless the state is IDLE.
REQ-005 abort  input  1  synchronous cancel of a running sweep.
REQ-006 golden  input  16  expected truth table; captured on accepted start.
REQ-007 drv_a, drv_b, drv_c  output  1 each  drive inputs A, B, C of the 3-input/2-output netlist.
REQ-008 obs_p, obs_q  input  1 each  netlist outputs P, Q.
REQ-009 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  captured truth equals captured golden; valid from done, held until the next accepted start.
REQ-012 truth  output  16  captured truth table.
REQ-013 vec_idx  output  3  vector currently driven.
REQ-014 fail_idx  output  3  first mismatching vector index; 0 if none.

Function
REQ-015 Vector encoding: {drv_a,drv_b,drv_c} = vec_idx, A is the MSB.
REQ-016 Packing: truth[2i+1] = P and truth[2i] = Q for vector i.
REQ-017 States: IDLE, SETTLE, SAMPLE, DONE.
REQ-018 IDLE + start: golden_q <= golden, truth <= 0, vec_idx <= 0, fail flag cleared, settle count <= SETTLE_CYCLES, go to SETTLE.
REQ-019 SETTLE: decrement the count each cycle; when the count reaches 1, go to SAMPLE (SETTLE occupies exactly SETTLE_CYCLES cycles).
REQ-020 SAMPLE: write obs_p/obs_q into the truth bits for vec_idx.
REQ-021 SAMPLE compare: if the pair differs from golden_q bits and the fail flag is clear, set the flag and latch fail_idx <= vec_idx.
REQ-022 SAMPLE exit: if vec_idx = 7, go to DONE; otherwise increment vec_idx, reload the count, and go to SETTLE.
REQ-023 DONE: done = 1 for one cycle, pass <= (truth == golden_q), then go to IDLE.
REQ-024 Latency: done is high in the (8*(SETTLE_CYCLES+1)+1)th cycle after the start edge; 25 cycles at the default.
REQ-025 Drive outputs change only on entry to SETTLE, so they are stable across every SETTLE and SAMPLE cycle.
REQ-026 start while busy is ignored and the running sweep is unaffected.
REQ-027 Changes on golden during a sweep have no effect.
REQ-028 abort in SETTLE or SAMPLE: return to IDLE next cycle with no done pulse; pass <= 0; truth keeps its partial value.
REQ-029 abort and start in the same IDLE cycle: start wins.
REQ-030 abort in DONE: ignored; done still pulses.
REQ-031 vec_idx does not wrap; the sweep ends at 7.

Reset
REQ-032 While rst is high, all outputs are 0 and the state is IDLE, independent of clk.
REQ-033 rst asserted mid-sweep discards all captured data.

Structure
REQ-034 Package larger_sweep_pkg holds the state enum, NUM_VECTORS = 8, TRUTH_W = 16, and LARGER_GOLDEN = 16'h8404 (P = A&B&C, Q = C&~B).
REQ-035 Sub-module sweep_settle_timer (load, tick, expire) is the natural split; the netlist is instantiated beside this controller, not inside it.

Verification
REQ-036 Correct netlist, default SETTLE, golden = 16'h8404, start -> done in cycle 25; truth = 16'h8404, pass = 1, fail_idx = 0.
REQ-037 Correct netlist, golden = 16'h8400 -> pass = 0, fail_idx = 1, truth = 16'h8404.
REQ-038 start pulsed at cycle 5 of a sweep and golden toggled mid-sweep -> single done at cycle 25; pass reflects the golden value captured at start.
REQ-039 abort in cycle 10 -> busy drops at cycle 11, no done, pass = 0; a following start completes normally.
REQ-040 SETTLE_CYCLES = 1 -> each vector is held 1 cycle then sampled, done in cycle 17; SETTLE_CYCLES = 15 -> done in cycle 129.
REQ-041 rst pulsed mid-SETTLE with no clk edge -> all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/larger_sweep_pkg.sv
// -----------------------------------------------------------------------------
// larger_sweep_pkg
// Shared definitions for the exhaustive truth-table sweep controller.
//   sweep_state_t : controller state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   NUM_VECTORS   : number of input vectors of the 3-input netlist
//   TRUTH_W       : width of the packed {P,Q} truth table
//   LARGER_GOLDEN : reference table for P = A&B&C, Q = C&~B
//   truth_pair()  : extracts the {P,Q} pair belonging to one vector
// -----------------------------------------------------------------------------
package larger_sweep_pkg;

   localparam int NUM_VECTORS = 8;
   localparam int TRUTH_W     = 16;
   localparam int VEC_W       = 3;
   localparam int CNT_W       = 4;

   localparam logic [TRUTH_W-1:0] LARGER_GOLDEN = 16'h8404;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } sweep_state_t;

   // Vector i occupies bits [2i+1:2i] as {P,Q}.
   function automatic logic [1:0] truth_pair(input logic [TRUTH_W-1:0] table_in,
                                             input logic [VEC_W-1:0]   idx);
      return table_in[{idx, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// -----------------------------------------------------------------------------
// sweep_settle_timer
// Down-counter that measures how long each input vector is held.
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset
//   i_load   : reload the count with SETTLE_CYCLES
//   i_tick   : decrement the count by one (saturates at 0)
//   o_expire : high while the count equals 1, i.e. the last settle cycle
// -----------------------------------------------------------------------------
module sweep_settle_timer
   import larger_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_tick,
   output logic o_expire
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= LOAD_VAL;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Expiring on 1 rather than 0 makes SETTLE last exactly SETTLE_CYCLES cycles.
   assign o_expire = (r_count == CNT_W'(1));

endmodule

// File: rtl/larger_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// larger_sweep_ctrl
// Drives all 8 input vectors into an external 3-input/2-output netlist, lets
// each settle, captures {P,Q} into a truth table and compares it with a golden
// table captured at start.
//   clk, rst            : clock, asynchronous active-high reset
//   start, abort        : begin a sweep (IDLE only) / cancel a running sweep
//   golden[15:0]        : expected table, captured on an accepted start
//   drv_a/b/c           : netlist inputs, {A,B,C} = vec_idx
//   obs_p, obs_q        : netlist outputs
//   busy, done          : sweep in progress / one-cycle completion pulse
//   pass                : captured truth equals captured golden
//   truth[15:0]         : captured table, {P,Q} of vector i at [2i+1:2i]
//   vec_idx[2:0]        : vector being driven
//   fail_idx[2:0]       : first mismatching vector (0 when none)
// -----------------------------------------------------------------------------
module larger_sweep_ctrl
   import larger_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [TRUTH_W-1:0] golden,
   output logic               drv_a,
   output logic               drv_b,
   output logic               drv_c,
   input  logic               obs_p,
   input  logic               obs_q,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [TRUTH_W-1:0] truth,
   output logic [VEC_W-1:0]   vec_idx,
   output logic [VEC_W-1:0]   fail_idx
);

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

   sweep_state_t       r_state;
   logic [TRUTH_W-1:0] r_golden;
   logic [TRUTH_W-1:0] r_truth;
   logic [VEC_W-1:0]   r_vec_idx;
   logic [VEC_W-1:0]   r_fail_idx;
   logic               r_fail_flag;
   logic               r_pass;

   logic               w_accept;
   logic               w_load;
   logic               w_tick;
   logic               w_expire;
   logic               w_mismatch;
   logic [TRUTH_W-1:0] w_truth_next;

   assign w_accept   = (r_state == ST_IDLE) && start;
   // Reload on start and on every non-final sample, so drive and count move together.
   assign w_load     = w_accept ||
                       ((r_state == ST_SAMPLE) && !abort && (r_vec_idx != LAST_VEC));
   assign w_tick     = (r_state == ST_SETTLE);
   assign w_mismatch = ({obs_p, obs_q} != truth_pair(r_golden, r_vec_idx));

   always_comb begin
      w_truth_next = r_truth;
      w_truth_next[{r_vec_idx, 1'b0} +: 2] = {obs_p, obs_q};
   end

   sweep_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_timer (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_load   (w_load),
      .i_tick   (w_tick),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_golden    <= '0;
         r_truth     <= '0;
         r_vec_idx   <= '0;
         r_fail_idx  <= '0;
         r_fail_flag <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_golden    <= golden;
                  r_truth     <= '0;
                  r_vec_idx   <= '0;
                  r_fail_idx  <= '0;
                  r_fail_flag <= 1'b0;
                  r_pass      <= 1'b0;
                  r_state     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  r_pass  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_expire) begin
                  r_state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (abort) begin
                  r_pass  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_truth <= w_truth_next;
                  if (w_mismatch && !r_fail_flag) begin
                     r_fail_flag <= 1'b1;
                     r_fail_idx  <= r_vec_idx;
                  end
                  if (r_vec_idx == LAST_VEC) begin
                     // Resolve the verdict one cycle early so pass is valid alongside done.
                     r_pass  <= (w_truth_next == r_golden);
                     r_state <= ST_DONE;
                  end else begin
                     r_vec_idx <= r_vec_idx + 1'b1;
                     r_state   <= ST_SETTLE;
                  end
               end
            end
            ST_DONE: begin
               r_pass  <= (r_truth == r_golden);
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);
   assign pass     = r_pass;
   assign truth    = r_truth;
   assign vec_idx  = r_vec_idx;
   assign fail_idx = r_fail_idx;
   assign drv_a    = r_vec_idx[2];
   assign drv_b    = r_vec_idx[1];
   assign drv_c    = r_vec_idx[0];

endmodule

// File: tb/tb_larger_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_larger_sweep_ctrl
// Directed bench for larger_sweep_ctrl at SETTLE_CYCLES = 2 (default), 1 and 15,
// each driving its own copy of the P = A&B&C, Q = C&~B netlist.
// -----------------------------------------------------------------------------
module tb_larger_sweep_ctrl;
   import larger_sweep_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start1, start15, abort;
   logic [15:0] golden;

   logic        d0_a, d0_b, d0_c, d0_p, d0_q, d0_busy, d0_done, d0_pass;
   logic [15:0] d0_truth;
   logic [2:0]  d0_vec, d0_fail;
   logic        d1_a, d1_b, d1_c, d1_p, d1_q, d1_busy, d1_done, d1_pass;
   logic [15:0] d1_truth;
   logic [2:0]  d1_vec, d1_fail;
   logic        d15_a, d15_b, d15_c, d15_p, d15_q, d15_busy, d15_done, d15_pass;
   logic [15:0] d15_truth;
   logic [2:0]  d15_vec, d15_fail;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign d0_p  = d0_a & d0_b & d0_c;
   assign d0_q  = d0_c & ~d0_b;
   assign d1_p  = d1_a & d1_b & d1_c;
   assign d1_q  = d1_c & ~d1_b;
   assign d15_p = d15_a & d15_b & d15_c;
   assign d15_q = d15_c & ~d15_b;

   larger_sweep_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
      .drv_a(d0_a), .drv_b(d0_b), .drv_c(d0_c), .obs_p(d0_p), .obs_q(d0_q),
      .busy(d0_busy), .done(d0_done), .pass(d0_pass), .truth(d0_truth),
      .vec_idx(d0_vec), .fail_idx(d0_fail));

   larger_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .golden(LARGER_GOLDEN),
      .drv_a(d1_a), .drv_b(d1_b), .drv_c(d1_c), .obs_p(d1_p), .obs_q(d1_q),
      .busy(d1_busy), .done(d1_done), .pass(d1_pass), .truth(d1_truth),
      .vec_idx(d1_vec), .fail_idx(d1_fail));

   larger_sweep_ctrl #(.SETTLE_CYCLES(15)) u_dut15 (
      .clk(clk), .rst(rst), .start(start15), .abort(1'b0), .golden(LARGER_GOLDEN),
      .drv_a(d15_a), .drv_b(d15_b), .drv_c(d15_c), .obs_p(d15_p), .obs_q(d15_q),
      .busy(d15_busy), .done(d15_done), .pass(d15_pass), .truth(d15_truth),
      .vec_idx(d15_vec), .fail_idx(d15_fail));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accepts a start on the default DUT; returns positioned in cycle 1.
   task automatic kick();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Observes the default DUT for ncyc cycles after a start, applying optional
   // abort / extra start / golden change in the given cycles (-1 = never).
   task automatic watch(input int ncyc, input int abort_at, input int start_at,
                        input int gold_at, input logic [15:0] gold_val,
                        output int done_cyc, output int ndone,
                        output logic [15:0] t_at, output logic p_at,
                        output logic [2:0] f_at, output int busy_low_at,
                        output bit drv_bad);
      done_cyc = -1; ndone = 0; t_at = 'x; p_at = 1'bx; f_at = 'x;
      busy_low_at = -1; drv_bad = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         if (d0_done) begin
            ndone++;
            if (done_cyc < 0) begin
               done_cyc = c; t_at = d0_truth; p_at = d0_pass; f_at = d0_fail;
            end
         end
         if (!d0_busy && busy_low_at < 0) busy_low_at = c;
         // Vector k is driven in cycles 3k+1 .. 3k+3 at the default settle time.
         if (c <= 24 && (abort_at < 0 || c <= abort_at)) begin
            if ({d0_a, d0_b, d0_c} !== 3'((c - 1) / 3)) drv_bad = 1'b1;
         end
         abort = (c == abort_at);
         start = (c == start_at);
         if (c == gold_at) golden = gold_val;
         step();
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({d0_busy, d0_done, d0_pass, d0_a, d0_b, d0_c} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {d0_busy, d0_done, d0_pass, d0_a, d0_b, d0_c});
      end
      checks++;
      if ({d0_truth, d0_vec, d0_fail} !== 22'h0) begin
         errors++;
         $display("FAIL reset_data: got truth=%h vec=%0d fail=%0d expected 0",
                  d0_truth, d0_vec, d0_fail);
      end
      rst = 1'b0;
      step();
      $display("test_reset done");
   endtask

   task automatic test_nominal();
      int dc, nd, bl; logic [15:0] t; logic p; logic [2:0] f; bit db;
      golden = LARGER_GOLDEN;
      kick();
      watch(30, -1, -1, -1, 16'h0, dc, nd, t, p, f, bl, db);
      checks++;
      if (dc != 25 || nd != 1) begin
         errors++;
         $display("FAIL nominal_latency: got cycle %0d count %0d expected cycle 25 count 1", dc, nd);
      end
      checks++;
      if (t !== 16'h8404 || p !== 1'b1 || f !== 3'd0) begin
         errors++;
         $display("FAIL nominal_result: got truth=%h pass=%b fail=%0d expected 8404 1 0", t, p, f);
      end
      checks++;
      if (bl != 26) begin
         errors++;
         $display("FAIL nominal_busy: got busy low at %0d expected 26", bl);
      end
      checks++;
      if (db) begin
         errors++;
         $display("FAIL nominal_drive: got drive off schedule expected vector (c-1)/3");
      end
      checks++;
      if (d0_pass !== 1'b1) begin
         errors++;
         $display("FAIL nominal_pass_hold: got %b expected 1", d0_pass);
      end
      $display("test_nominal done: done_cycle=%0d truth=%h", dc, t);
   endtask

   task automatic test_mismatch();
      int dc, nd, bl; logic [15:0] t; logic p; logic [2:0] f; bit db;
      golden = 16'h8400;
      kick();
      watch(30, -1, -1, -1, 16'h0, dc, nd, t, p, f, bl, db);
      checks++;
      if (dc != 25 || t !== 16'h8404 || p !== 1'b0 || f !== 3'd1) begin
         errors++;
         $display("FAIL mismatch: got cycle=%0d truth=%h pass=%b fail=%0d expected 25 8404 0 1",
                  dc, t, p, f);
      end
      $display("test_mismatch done: fail_idx=%0d", f);
   endtask

   task automatic test_back_to_back();
      int dc, nd, bl; logic [15:0] t; logic p; logic [2:0] f; bit db;
      golden = LARGER_GOLDEN;
      kick();
      watch(40, -1, 5, 8, 16'h0000, dc, nd, t, p, f, bl, db);
      checks++;
      if (dc != 25 || nd != 1) begin
         errors++;
         $display("FAIL b2b_single_done: got cycle %0d count %0d expected 25 1", dc, nd);
      end
      checks++;
      if (p !== 1'b1 || d0_pass !== 1'b1) begin
         errors++;
         $display("FAIL b2b_golden_captured: got pass=%b/%b expected 1", p, d0_pass);
      end
      golden = LARGER_GOLDEN;
      $display("test_back_to_back done: done_count=%0d", nd);
   endtask

   task automatic test_abort();
      int dc, nd, bl; logic [15:0] t; logic p; logic [2:0] f; bit db;
      golden = LARGER_GOLDEN;
      kick();
      watch(30, 10, -1, -1, 16'h0, dc, nd, t, p, f, bl, db);
      checks++;
      if (bl != 11 || nd != 0) begin
         errors++;
         $display("FAIL abort_stop: got busy low at %0d done count %0d expected 11 0", bl, nd);
      end
      checks++;
      if (d0_pass !== 1'b0 || d0_truth !== 16'h0004) begin
         errors++;
         $display("FAIL abort_state: got pass=%b truth=%h expected 0 0004", d0_pass, d0_truth);
      end
      kick();
      watch(30, -1, -1, -1, 16'h0, dc, nd, t, p, f, bl, db);
      checks++;
      if (dc != 25 || p !== 1'b1 || t !== 16'h8404) begin
         errors++;
         $display("FAIL abort_recover: got cycle=%0d pass=%b truth=%h expected 25 1 8404", dc, p, t);
      end
      $display("test_abort done: busy_low=%0d", bl);
   endtask

   task automatic test_abort_priority();
      int dc, nd, bl; logic [15:0] t; logic p; logic [2:0] f; bit db;
      golden = LARGER_GOLDEN;
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (d0_busy !== 1'b1) begin
         errors++;
         $display("FAIL start_beats_abort: got busy=%b expected 1", d0_busy);
      end
      // Abort raised only in the DONE cycle must not disturb completion.
      watch(30, 25, -1, -1, 16'h0, dc, nd, t, p, f, bl, db);
      checks++;
      if (dc != 25 || nd != 1 || d0_pass !== 1'b1 || bl != 26) begin
         errors++;
         $display("FAIL abort_in_done: got cycle=%0d count=%0d pass=%b busy_low=%0d expected 25 1 1 26",
                  dc, nd, d0_pass, bl);
      end
      $display("test_abort_priority done: done_cycle=%0d", dc);
   endtask

   task automatic test_settle_range();
      int dc1 = -1, dc15 = -1, n1 = 0, n15 = 0;
      logic [15:0] t1 = 'x, t15 = 'x;
      logic p1 = 1'bx, p15 = 1'bx;
      start1  = 1'b1;
      start15 = 1'b1;
      step();
      start1  = 1'b0;
      start15 = 1'b0;
      for (int c = 1; c <= 140; c++) begin
         if (d1_done) begin
            n1++;
            if (dc1 < 0) begin dc1 = c; t1 = d1_truth; p1 = d1_pass; end
         end
         if (d15_done) begin
            n15++;
            if (dc15 < 0) begin dc15 = c; t15 = d15_truth; p15 = d15_pass; end
         end
         step();
      end
      checks++;
      if (dc1 != 17 || n1 != 1 || t1 !== 16'h8404 || p1 !== 1'b1) begin
         errors++;
         $display("FAIL settle1: got cycle=%0d count=%0d truth=%h pass=%b expected 17 1 8404 1",
                  dc1, n1, t1, p1);
      end
      checks++;
      if (dc15 != 129 || n15 != 1 || t15 !== 16'h8404 || p15 !== 1'b1) begin
         errors++;
         $display("FAIL settle15: got cycle=%0d count=%0d truth=%h pass=%b expected 129 1 8404 1",
                  dc15, n15, t15, p15);
      end
      $display("test_settle_range done: done1=%0d done15=%0d", dc1, dc15);
   endtask

   task automatic test_async_reset();
      golden = LARGER_GOLDEN;
      kick();
      for (int c = 1; c < 7; c++) step();
      // Cycle 7: vector 2 settling, truth already holds vector 1's Q bit.
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({d0_busy, d0_done, d0_pass, d0_a, d0_b, d0_c} !== 6'b0 ||
          d0_truth !== 16'h0 || d0_vec !== 3'd0 || d0_fail !== 3'd0) begin
         errors++;
         $display("FAIL async_reset: got busy=%b drv=%b truth=%h vec=%0d expected all 0",
                  d0_busy, {d0_a, d0_b, d0_c}, d0_truth, d0_vec);
      end
      step();
      rst = 1'b0;
      step();
      checks++;
      if (d0_busy !== 1'b0 || d0_truth !== 16'h0) begin
         errors++;
         $display("FAIL async_reset_idle: got busy=%b truth=%h expected 0 0000", d0_busy, d0_truth);
      end
      $display("test_async_reset done");
   endtask

   initial begin
      rst     = 1'b0;
      start   = 1'b0;
      start1  = 1'b0;
      start15 = 1'b0;
      abort   = 1'b0;
      golden  = 16'h0;
      #1;
      test_reset();
      test_nominal();
      test_mismatch();
      test_back_to_back();
      test_abort();
      test_abort_priority();
      test_settle_range();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
